alu_issue_stage: RTL

- Sequential front-end that sits directly upstream of the team's combinational 8-bit ALU and consumes its outputs.
- Accepts instructions over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU operand and opcode inputs for one cycle, then registers the ALU result and zero flag.
- Writes the result back to the register file and presents it on a valid/ready result port. Also provides a host register write port and a debug read port.

---
 rtl/alu_issue_stage_if.sv | 41 ++++
 rtl/alu_issue_stage.sv | 91 +++++++++
 2 files changed

// File: rtl/alu_issue_stage_if.sv
// Bundles the instruction, ALU, result, host-write and debug signals of alu_issue_stage.
// The slave modport is the stage. The master modport is its surroundings: the issuer, the ALU, the consumer and the host.
interface alu_issue_stage_if #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2
);
  localparam int IW = 3 + 3*RA_W;

  logic              instr_valid;
  logic              instr_ready;
  logic [IW-1:0]     instr;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_opcode;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_zero;
  logic [RA_W-1:0]   res_rd;
  logic              wr_en;
  logic [RA_W-1:0]   wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [RA_W-1:0]   dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport slave (
    input  instr_valid, instr, alu_result, alu_zero, res_ready,
           wr_en, wr_addr, wr_data, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_opcode, res_valid,
           res_data, res_zero, res_rd, dbg_data
  );

  modport master (
    output instr_valid, instr, alu_result, alu_zero, res_ready,
           wr_en, wr_addr, wr_data, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_opcode, res_valid,
           res_data, res_zero, res_rd, dbg_data
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the combinational ALU. It runs IDLE -> EXEC -> WB.
// Operands come from a small register file, and the ALU result is written back and offered on the result port.
module alu_issue_stage #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_stage_if.slave  bus
);
  localparam int NREG = 2**RA_W;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  typedef struct packed {
    logic [2:0]      op;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
  } instr_t;

  state_t            r_state, w_next;
  instr_t            r_instr;
  logic [DATA_W-1:0] r_rf [NREG];
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_zero;
  logic [RA_W-1:0]   r_res_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.instr_valid) w_next = EXEC;
      EXEC:    w_next = WB;
      WB:      if (bus.res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.instr_ready = 1'b0;
    bus.res_valid   = 1'b0;
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.alu_opcode  = '0;
    case (r_state)
      IDLE: bus.instr_ready = 1'b1;
      EXEC: begin
        bus.alu_a      = r_rf[r_instr.rs1];
        bus.alu_b      = r_rf[r_instr.rs2];
        bus.alu_opcode = r_instr.op;
      end
      WB:      bus.res_valid = 1'b1;
      default: ;
    endcase
  end

  // Host writes and write-back are mutually exclusive by state, so the register file has one writer per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= '0;
      r_res_data <= '0;
      r_res_zero <= 1'b0;
      r_res_rd   <= '0;
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.instr_valid) r_instr <= instr_t'(bus.instr);
          if (bus.wr_en)       r_rf[bus.wr_addr] <= bus.wr_data;
        end
        EXEC: begin
          r_rf[r_instr.rd] <= bus.alu_result;
          r_res_data       <= bus.alu_result;
          r_res_zero       <= bus.alu_zero;
          r_res_rd         <= r_instr.rd;
        end
        default: ;
      endcase
    end
  end

  assign bus.res_data = r_res_data;
  assign bus.res_zero = r_res_zero;
  assign bus.res_rd   = r_res_rd;
  assign bus.dbg_data = r_rf[bus.dbg_addr];
endmodule
